// File: rtl/lut_layer_pkg.sv
// Shared types and width helpers for the LUT neuron layer.
// Table address width and the neuron-select width are derived here so every file agrees.
package lut_layer_pkg;

  typedef enum logic {INIT, RUN} layer_state_t;

  function automatic int addr_width(input int fan_in, input int in_bits);
    return fan_in * in_bits;
  endfunction

  // Neuron select needs at least one bit even for a single-neuron layer.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_table.sv
// One neuron's truth table: distributed RAM, synchronous write, asynchronous read.
// The read port is unregistered here; the parent layer registers it in its output stage.
module lut_neuron_table #(
  parameter int ADDR_W   = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_BITS-1:0] mem [2**ADDR_W];

  // No reset on the array: the layer clears it with an INIT sweep instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_layer_pipe.sv
// Pipelined layer of N_NEURONS LUT neurons with run-time loadable tables.
// Tables are cleared by an INIT sweep after reset, then loaded through the cfg port.
//
// state | meaning
// INIT  | sweeping every table entry to zero, one address per cycle
// RUN   | accepting activations and table writes
module lut_neuron_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter  int N_NEURONS = 4,
  parameter  int FAN_IN    = 4,
  parameter  int IN_BITS   = 2,
  parameter  int OUT_BITS  = 2,
  localparam int ADDR_W    = addr_width(FAN_IN, IN_BITS),
  localparam int SEL_W     = sel_width(N_NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*ADDR_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_we,
  input  logic [SEL_W-1:0]              cfg_neuron,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_err,
  output logic                          init_done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(DEPTH - 1);

  layer_state_t                  state;
  logic [CNT_W-1:0]              sweep_cnt;
  logic                          en;
  logic                          s1_valid;
  logic [N_NEURONS*ADDR_W-1:0]   s1_data;
  logic [N_NEURONS-1:0]          hit;
  logic [N_NEURONS-1:0]          tbl_we;
  logic [ADDR_W-1:0]             tbl_waddr;
  logic [OUT_BITS-1:0]           tbl_wdata;
  logic [N_NEURONS*OUT_BITS-1:0] rd_data;

  assign en       = !out_valid || out_ready;
  assign in_ready = (state == RUN) && !cfg_we && en;

  // INIT owns the write port of every table; in RUN the cfg port drives it.
  assign tbl_waddr = (state == INIT) ? sweep_cnt[ADDR_W-1:0] : cfg_addr;
  assign tbl_wdata = (state == INIT) ? '0 : cfg_data;

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    assign hit[n]    = (cfg_neuron == SEL_W'(n));
    assign tbl_we[n] = (state == INIT) || (cfg_we && hit[n]);

    lut_neuron_table #(
      .ADDR_W   (ADDR_W),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk   (clk),
      .we    (tbl_we[n]),
      .waddr (tbl_waddr),
      .wdata (tbl_wdata),
      .raddr (s1_data[n*ADDR_W +: ADDR_W]),
      .rdata (rd_data[n*OUT_BITS +: OUT_BITS])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      // An out-of-range neuron matches no hit bit, so it is rejected too.
      cfg_err <= cfg_we && ((state == INIT) || !(|hit));
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + CNT_W'(1);
          if (sweep_cnt == SWEEP_LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Stage 2 samples the tables on the same edge a cfg write lands: read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      s1_valid  <= in_valid && in_ready;
      s1_data   <= in_data;
      out_valid <= s1_valid;
      out_data  <= rd_data;
    end
  end

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Directed bench for lut_neuron_layer_pipe; a second 3-neuron instance exercises
// the out-of-range neuron select that the 4-neuron port cannot express.
module tb_lut_neuron_layer_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_err;
  logic        init_done;

  logic        d2_in_ready;
  logic        d2_out_valid;
  logic [5:0]  d2_out_data;
  logic [1:0]  d2_neuron = 2'd3;
  logic        d2_cfg_err;
  logic        d2_init_done;

  int passed = 0;
  int total  = 0;
  int c, tx, rx;
  logic [7:0] held;
  logic       acc;

  always #5 clk = ~clk;

  lut_neuron_layer_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .init_done(init_done)
  );

  lut_neuron_layer_pipe #(.N_NEURONS(3)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data[23:0]),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .cfg_we(cfg_we), .cfg_neuron(d2_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(d2_cfg_err), .init_done(d2_init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] n, input logic [7:0] a, input logic [1:0] d);
    cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
    #1 check("cfg_blocks_in_ready", in_ready, 0);
    step();
    cfg_we = 1'b0;
    check("cfg_err_valid_write", cfg_err, 0);
    check("d2_cfg_err_bad_neuron", d2_cfg_err, 1);
  endtask

  task automatic read_word(input string tag, input logic [31:0] w, input logic [7:0] exp);
    in_valid = 1'b1; in_data = w;
    #1 check({tag, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    step();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_d2"}, d2_out_data, 0);
  endtask

  task automatic init_wait(input string tag, input bit poke_cfg);
    for (int i = 1; i <= 256; i++) begin
      if (poke_cfg && i == 10) begin
        cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 8'h05; cfg_data = 2'b11;
      end
      step();
      if (poke_cfg && i == 10) begin
        cfg_we = 1'b0;
        check("init_cfg_err_pulse", cfg_err, 1);
      end
      if (poke_cfg && i == 11) check("init_cfg_err_clear", cfg_err, 0);
      if (i == 255) begin
        check({tag, "_done_early"}, init_done, 0);
        check({tag, "_ready_early"}, in_ready, 0);
      end
    end
    check({tag, "_done"}, init_done, 1);
    check({tag, "_ready"}, in_ready, 1);
  endtask

  function automatic logic [7:0] stream_exp(input int k);
    logic [3:0] kb;
    kb = 4'(k);
    return {kb[1:0] ^ kb[3:2], 6'b0};
  endfunction

  task automatic stream(input string tag, input bit bp, input int exp_cycles);
    tx = 0; rx = 0;
    for (c = 0; c < 40 && rx < 16; c++) begin
      out_ready = !(bp && c >= 4 && c < 9);
      in_valid  = (tx < 16);
      in_data   = {8'(tx), 24'h0};
      #1;
      if (out_valid && out_ready) begin
        check({tag, "_data"}, out_data, stream_exp(rx));
        rx++;
      end
      if (out_valid && !out_ready) begin
        check({tag, "_hold_ready"}, in_ready, 0);
        if (c > 4) check({tag, "_hold_stable"}, out_data, held);
        held = out_data;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check({tag, "_count"}, rx, 16);
    check({tag, "_cycles"}, c, exp_cycles);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_init_done", init_done, 0);
    #4 rst = 1'b0;
    init_wait("init", 1'b1);

    read_word("clear_05", {4{8'h05}}, 8'h00);
    read_word("clear_mix", 32'hFF00_A53C, 8'h00);

    cfg_write(2'd0, 8'hCE, 2'b01);
    cfg_write(2'd0, 8'hCF, 2'b01);
    cfg_write(2'd2, 8'h33, 2'b10);
    step();
    check("d2_cfg_err_one_cycle", d2_cfg_err, 0);
    read_word("n0_ce", 32'h0000_00CE, 8'h01);
    read_word("n0_cd", 32'h0000_00CD, 8'h00);
    read_word("n0_cf", 32'h0000_00CF, 8'h01);
    read_word("n2_n0", 32'h0033_00CE, 8'h21);

    for (int k = 0; k < 16; k++) cfg_write(2'd3, 8'(k), stream_exp(k)[7:6]);
    stream("flow", 1'b0, 18);
    stream("bp", 1'b1, 23);

    // Read-before-write on 0x12 of neuron 0.
    in_valid = 1'b1; in_data = 32'h0000_0012;
    step();
    cfg_write(2'd0, 8'h12, 2'b11);
    check("rbw_old_valid", out_valid, 1);
    check("rbw_old_data", out_data, 8'h00);
    step();
    in_valid = 1'b0;
    check("rbw_bubble", out_valid, 0);
    step();
    check("rbw_new_valid", out_valid, 1);
    check("rbw_new_data", out_data, 8'h03);

    // Asynchronous reset with two items in flight.
    in_valid = 1'b1; in_data = 32'h0000_00CE;
    step();
    in_data = 32'h0000_0012;
    step();
    in_valid = 1'b0;
    check("flight_valid", out_valid, 1);
    check("flight_data", out_data, 8'h01);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_done", init_done, 0);
    check("async_rst_ready", in_ready, 0);
    step();
    #4 rst = 1'b0;
    init_wait("reinit", 1'b0);
    check("reinit_no_stale_out", out_valid, 0);
    read_word("reinit_ce", 32'h0000_00CE, 8'h00);
    read_word("reinit_12", 32'h0000_0012, 8'h00);
    read_word("reinit_33", 32'h0033_0000, 8'h00);
    read_word("reinit_n3", 32'h0600_0000, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
